conv3x3_window_sequencer: RTL and testbench

Parametrised window-position sequencer for the 3x3 convolution datapath. It sits between the line buffer and the multiplier bar. It tracks the line-buffer fill, the window centre (x, y) and the channel index across a whole layer, and issues per-tap border-padding enables. Compared with the fixed 112x112 single-channel counter group, it adds:
- configurable image size and channel count,
- stride-2 mode,
- a self-driven drain phase that flushes the last W+1 windows of a layer,
- registered, glitch-free valid and done strobes.

---
 rtl/conv3x3_window_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_conv3x3_window_sequencer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/conv3x3_window_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | conv3x3_window_sequencer: 3x3 window position, channel and padding-mask  |
// | sequencer between the line buffer and the multiplier bar.                |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module conv3x3_window_sequencer #(
  parameter int IMG_W  = 112,
  parameter int IMG_H  = 112,
  parameter int NUM_CH = 64,
  parameter int XW     = (IMG_W  > 1) ? $clog2(IMG_W)  : 1,
  parameter int YW     = (IMG_H  > 1) ? $clog2(IMG_H)  : 1,
  parameter int CHW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           stride2,
  input  logic           valid_i,
  output logic           in_ready,
  output logic           drain_o,
  output logic           win_valid,
  output logic [8:0]     enable,
  output logic           valid_o,
  output logic           chnl_done,
  output logic           layer_done,
  output logic           busy,
  output logic [XW-1:0]  x_o,
  output logic [YW-1:0]  y_o,
  output logic [CHW-1:0] ch_o
);

  localparam int FW = $clog2(IMG_W + 1);

  localparam logic [FW-1:0]  FILL_LAST = FW'(IMG_W);
  localparam logic [XW-1:0]  X_LAST    = XW'(IMG_W - 1);
  localparam logic [XW-1:0]  X_PEN     = XW'(IMG_W - 2);
  localparam logic [YW-1:0]  Y_LAST    = YW'(IMG_H - 1);
  localparam logic [YW-1:0]  Y_PEN     = YW'(IMG_H - 2);
  localparam logic [CHW-1:0] CH_LAST   = CHW'(NUM_CH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_RUN   = 2'd2,
    S_DRAIN = 2'd3
  } state_e;

  state_e         state_q, state_d;
  logic [FW-1:0]  fill_q, fill_d;
  logic [XW-1:0]  x_q, x_d;
  logic [YW-1:0]  y_q, y_d;
  logic [CHW-1:0] ch_q, ch_d;
  logic           stride_q, stride_d;
  logic           valid_q;
  logic           chnl_done_q;
  logic           layer_done_q;

  logic           step;
  logic           active;
  logic           x_last;
  logic           y_last;
  logic           ch_last;
  logic           chnl_end;
  logic           layer_end;
  logic           last_beat;

  assign x_last    = (x_q == X_LAST);
  assign y_last    = (y_q == Y_LAST);
  assign ch_last   = (ch_q == CH_LAST);
  assign chnl_end  = x_last && y_last;
  assign layer_end = (state_q == S_DRAIN) && ch_last && chnl_end;
  // The last input beat leaves exactly IMG_W+1 windows for the drain phase.
  assign last_beat = ch_last && (y_q == Y_PEN) && (x_q == X_PEN);
  assign active    = (state_q == S_RUN) || (state_q == S_DRAIN);

  always_comb begin
    state_d  = state_q;
    fill_d   = fill_q;
    x_d      = x_q;
    y_d      = y_q;
    ch_d     = ch_q;
    stride_d = stride_q;
    step     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_FILL;
          fill_d   = '0;
          x_d      = '0;
          y_d      = '0;
          ch_d     = '0;
          stride_d = stride2;
        end
      end
      S_FILL: begin
        if (valid_i) begin
          if (fill_q == FILL_LAST) begin
            state_d = S_RUN;
            fill_d  = '0;
          end else begin
            fill_d = fill_q + 1'b1;
          end
        end
      end
      S_RUN: begin
        step = valid_i;
        if (valid_i && last_beat) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        step = 1'b1;
        if (layer_end) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (step) begin
      if (x_last) begin
        x_d = '0;
        if (y_last) begin
          y_d  = '0;
          ch_d = layer_end ? '0 : ch_q + 1'b1;
        end else begin
          y_d = y_q + 1'b1;
        end
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  // Padding mask: bit 3*r+c, r=0 above centre, c=0 left of centre.
  always_comb begin
    enable = 9'b0;
    if (active) begin
      enable = 9'h1FF;
      if (y_q == '0) begin
        enable[2:0] = 3'b000;
      end
      if (y_last) begin
        enable[8:6] = 3'b000;
      end
      if (x_q == '0) begin
        enable[0] = 1'b0;
        enable[3] = 1'b0;
        enable[6] = 1'b0;
      end
      if (x_last) begin
        enable[2] = 1'b0;
        enable[5] = 1'b0;
        enable[8] = 1'b0;
      end
    end
  end

  assign win_valid = step && (!stride_q || (!x_q[0] && !y_q[0]));
  assign in_ready  = (state_q == S_FILL) || (state_q == S_RUN);
  assign drain_o   = (state_q == S_DRAIN);
  assign busy      = (state_q != S_IDLE);
  assign x_o       = x_q;
  assign y_o       = y_q;
  assign ch_o      = ch_q;
  assign valid_o   = valid_q;
  assign chnl_done = chnl_done_q;
  assign layer_done = layer_done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      fill_q       <= '0;
      x_q          <= '0;
      y_q          <= '0;
      ch_q         <= '0;
      stride_q     <= 1'b0;
      valid_q      <= 1'b0;
      chnl_done_q  <= 1'b0;
      layer_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      fill_q       <= fill_d;
      x_q          <= x_d;
      y_q          <= y_d;
      ch_q         <= ch_d;
      stride_q     <= stride_d;
      valid_q      <= win_valid;
      chnl_done_q  <= step && chnl_end;
      layer_done_q <= step && layer_end;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_conv3x3_window_sequencer.sv
`default_nettype none
// Directed table-driven bench for conv3x3_window_sequencer (4x3 image, 2 channels).
module tb_conv3x3_window_sequencer;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int NC = 2;

  localparam int K_IDLE  = 0;
  localparam int K_FILL  = 1;
  localparam int K_RUN   = 2;
  localparam int K_DRAIN = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       stride2;
  logic       valid_i;
  logic       in_ready;
  logic       drain_o;
  logic       win_valid;
  logic [8:0] enable;
  logic       valid_o;
  logic       chnl_done;
  logic       layer_done;
  logic       busy;
  logic [1:0] x_o;
  logic [1:0] y_o;
  logic [0:0] ch_o;

  conv3x3_window_sequencer #(
    .IMG_W (W),
    .IMG_H (H),
    .NUM_CH(NC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .stride2   (stride2),
    .valid_i   (valid_i),
    .in_ready  (in_ready),
    .drain_o   (drain_o),
    .win_valid (win_valid),
    .enable    (enable),
    .valid_o   (valid_o),
    .chnl_done (chnl_done),
    .layer_done(layer_done),
    .busy      (busy),
    .x_o       (x_o),
    .y_o       (y_o),
    .ch_o      (ch_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       st;
    logic       vin;
    logic       inrdy;
    logic       drain;
    logic       step;
    logic       busy;
    logic [1:0] x;
    logic [1:0] y;
    logic [0:0] ch;
    logic [8:0] en;
    logic       cdn;
    logic       ldn;
  } vec_t;

  vec_t       tbl[$];
  logic [8:0] en_tab [0:2][0:3];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         wv_cnt;
  int         vo_cnt;
  logic       prev_wv;
  logic       prev_cd;
  logic       prev_ld;

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s #%0d: got %h required %h", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic st, input logic vin, input int kind,
                     input int x, input int y, input int ch);
    vec_t v;
    v.st    = st;
    v.vin   = vin;
    v.inrdy = (kind == K_FILL) || (kind == K_RUN);
    v.drain = (kind == K_DRAIN);
    v.busy  = (kind != K_IDLE);
    v.step  = ((kind == K_RUN) && vin) || (kind == K_DRAIN);
    v.x     = 2'(x);
    v.y     = 2'(y);
    v.ch    = 1'(ch);
    v.en    = (kind >= K_RUN) ? en_tab[y][x] : 9'h000;
    v.cdn   = v.step && (x == W - 1) && (y == H - 1);
    v.ldn   = v.cdn && (ch == NC - 1);
    tbl.push_back(v);
  endtask

  // Drive one cycle, compare all outputs at the falling edge.
  task automatic apply(input vec_t v, input logic s2, input int idx);
    logic        exp_wv;
    logic [20:0] exp_v;
    logic [20:0] act_v;
    start   = v.st;
    valid_i = v.vin;
    stride2 = s2;
    exp_wv  = v.step && (!s2 || (!v.x[0] && !v.y[0]));
    @(negedge clk);
    exp_v = {v.inrdy, v.drain, exp_wv, v.en, prev_wv, prev_cd, prev_ld, v.busy,
             v.x, v.y, v.ch};
    act_v = {in_ready, drain_o, win_valid, enable, valid_o, chnl_done, layer_done,
             busy, x_o, y_o, ch_o};
    check("cycle", idx, 32'(act_v), 32'(exp_v));
    if (win_valid) wv_cnt++;
    if (valid_o) vo_cnt++;
    prev_wv = exp_wv;
    prev_cd = v.cdn;
    prev_ld = v.ldn;
    @(posedge clk);
    #1;
  endtask

  task automatic run_layer(input logic s2, input bit gaps, input int exp_wins);
    vec_t g;
    int   n;
    int   k;
    n       = 0;
    wv_cnt  = 0;
    vo_cnt  = 0;
    prev_wv = 1'b0;
    prev_cd = 1'b0;
    prev_ld = 1'b0;
    foreach (tbl[i]) begin
      if (gaps && tbl[i].vin && tbl[i].inrdy) begin
        k      = $urandom_range(0, 2);
        g      = tbl[i];
        g.st   = 1'b0;
        g.vin  = 1'b0;
        g.step = 1'b0;
        g.cdn  = 1'b0;
        g.ldn  = 1'b0;
        repeat (k) begin
          apply(g, s2, n);
          n++;
        end
      end
      apply(tbl[i], s2, n);
      n++;
    end
    check("win_valid count", n, 32'(wv_cnt), 32'(exp_wins));
    check("valid_o count", n, 32'(vo_cnt), 32'(exp_wins));
  endtask

  function automatic logic [20:0] all_outs();
    return {in_ready, drain_o, win_valid, enable, valid_o, chnl_done, layer_done,
            busy, x_o, y_o, ch_o};
  endfunction

  initial begin
    rst_n   = 1'b0;
    start   = 1'b0;
    stride2 = 1'b0;
    valid_i = 1'b0;

    en_tab[0][0] = 9'b110110000;
    en_tab[0][1] = 9'b111111000;
    en_tab[0][2] = 9'b111111000;
    en_tab[0][3] = 9'b011011000;
    en_tab[1][0] = 9'b110110110;
    en_tab[1][1] = 9'b111111111;
    en_tab[1][2] = 9'b111111111;
    en_tab[1][3] = 9'b011011011;
    en_tab[2][0] = 9'b000110110;
    en_tab[2][1] = 9'b000111111;
    en_tab[2][2] = 9'b000111111;
    en_tab[2][3] = 9'b000011011;

    // Layer trace: start, 5 fill beats, 19 run steps, 5 drain steps, idle.
    // Extra start pulses in RUN and on the final drain step must be ignored.
    add(1'b1, 1'b0, K_IDLE, 0, 0, 0);
    for (int i = 0; i < W + 1; i++) add(1'b0, 1'b1, K_FILL, 0, 0, 0);
    for (int p = 0; p < NC * W * H; p++) begin
      add((p == 7) || (p == NC * W * H - 1), 1'b1,
          (p < NC * W * H - (W + 1)) ? K_RUN : K_DRAIN,
          p % W, (p / W) % H, p / (W * H));
    end
    add(1'b0, 1'b1, K_IDLE, 0, 0, 0);
    add(1'b0, 1'b0, K_IDLE, 0, 0, 0);

    #3;
    check("reset outputs", 0, 32'(all_outs()), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_layer(1'b0, 1'b0, NC * W * H);
    run_layer(1'b0, 1'b1, NC * W * H);
    run_layer(1'b1, 1'b0, NC * 4);
    run_layer(1'b1, 1'b1, NC * 4);

    // Asynchronous reset in the middle of RUN.
    start   = 1'b1;
    stride2 = 1'b0;
    valid_i = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (W + 1 + 6) @(posedge clk);
    #2;
    check("busy before reset", 0, 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("outputs in reset", 0, 32'(all_outs()), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("idle after reset", i, 32'(all_outs()), 32'd0);
    end
    valid_i = 1'b0;
    @(posedge clk);
    #1;

    run_layer(1'b0, 1'b0, NC * W * H);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
